shift_pattern_ctrl: RTL

SHIFT_PATTERN_CTRL -- requirements
Module: shift_pattern_ctrl

---
 rtl/shift_ctrl_pkg.sv | 28 ++
 rtl/shift_dwell_timer.sv | 38 +++
 rtl/shift_pattern_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/shift_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : shift_ctrl_pkg
//  Brief    : Shared types and constants for the shift-pattern controller:
//             FSM state encoding, pattern mode encodings, toggle seed byte.
//  Revision : 1.0 - initial release
// ============================================================================
package shift_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_GAP      = 3'd2,
        ST_WAIT_RDY = 3'd3,
        ST_DWELL    = 3'd4,
        ST_UPDATE   = 3'd5
    } state_t;

    localparam logic [1:0] MODE_TOGGLE = 2'd0;
    localparam logic [1:0] MODE_WALK   = 2'd1;
    localparam logic [1:0] MODE_COUNT  = 2'd2;
    localparam logic [1:0] MODE_STATIC = 2'd3;

    // Byte replicated across the data width for the toggle pattern and reset
    localparam logic [7:0] TOGGLE_SEED = 8'h55;

endpackage
`default_nettype wire

// File: rtl/shift_dwell_timer.sv
`default_nettype none
// ============================================================================
//  Module   : shift_dwell_timer
//  Brief    : Dwell counter. Cleared while clear is high, advances on each
//             enabled cycle, done flags the final enabled dwell cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module shift_dwell_timer #(
    parameter int DWELL = 25000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic done
);

    // DWELL=1 still needs a one-bit counter to stay legal
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] count;

    // Count enabled cycles; freeze on hold and once the last cycle is reached
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !done) begin
            count <= count + CW'(1);
        end
    end

    assign done = enable && (count == LAST);

endmodule
`default_nettype wire

// File: rtl/shift_pattern_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : shift_pattern_ctrl
//  Brief    : Generates test patterns (toggle / walking-one / count / static)
//             for a shift-register driver, strobing each frame and dwelling
//             between updates.
//  Config   : SHIFT_CTRL_TIMEOUT_EN - enables the WAIT_RDY timeout, the
//             retry path and the sticky o_err flag.
//  Revision : 1.0 - initial release
// ============================================================================
module shift_pattern_ctrl #(
    parameter int WIDTH  = 8,
    parameter int DWELL  = 25000000,
    parameter int TO_CYC = 1024
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_rdy,
    input  logic [1:0]       i_mode,
    input  logic             i_hold,
    output logic [WIDTH-1:0] o_data,
    output logic             o_en_in,
    output logic [15:0]      o_frame_cnt,
    output logic             o_err
);

    import shift_ctrl_pkg::*;

    localparam logic [WIDTH-1:0] DATA_SEED = {(WIDTH/8){TOGGLE_SEED}};
    localparam logic [WIDTH-1:0] DATA_ONE  = WIDTH'(1);

    state_t           state;
    state_t           state_next;
    logic [1:0]       rst_pipe;
    logic             run;
    logic [1:0]       last_mode;
    logic [WIDTH-1:0] data_next;
    logic             dwell_clear;
    logic             dwell_done;
    logic             timeout;

    // Reset asserts immediately, release is delayed two clocks before the FSM may leave IDLE
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rst_pipe <= 2'b00;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign run = rst_pipe[1];

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (run) state_next = ST_LOAD;
            ST_LOAD:     state_next = ST_GAP;
            ST_GAP:      state_next = ST_WAIT_RDY;
            ST_WAIT_RDY: begin
                if (i_rdy) begin
                    state_next = ST_DWELL;
                end else if (timeout) begin
                    state_next = ST_LOAD;
                end
            end
            ST_DWELL:    if (dwell_done) state_next = ST_UPDATE;
            ST_UPDATE:   state_next = ST_LOAD;
            default:     state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: load strobe only in LOAD, dwell counter parked outside DWELL
    always_comb begin
        o_en_in     = (state == ST_LOAD);
        dwell_clear = (state != ST_DWELL);
    end

    shift_dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .clear  (dwell_clear),
        .enable (!i_hold),
        .done   (dwell_done)
    );

    // Pattern for the next frame: seed on a mode change, otherwise step
    always_comb begin
        data_next = o_data;
        if (i_mode != last_mode) begin
            case (i_mode)
                MODE_TOGGLE: data_next = DATA_SEED;
                MODE_WALK:   data_next = DATA_ONE;
                MODE_COUNT:  data_next = '0;
                default:     data_next = o_data;
            endcase
        end else begin
            case (i_mode)
                MODE_TOGGLE: data_next = ~o_data;
                MODE_WALK:   data_next = {o_data[WIDTH-2:0], o_data[WIDTH-1]};
                MODE_COUNT:  data_next = o_data + DATA_ONE;
                default:     data_next = o_data;
            endcase
        end
    end

    // Data and mode history change only in UPDATE, so o_data is stable LOAD..DWELL
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data    <= DATA_SEED;
            last_mode <= MODE_TOGGLE;
        end else if (state == ST_UPDATE) begin
            o_data    <= data_next;
            last_mode <= i_mode;
        end
    end

    // Frame counter advances when the driver reports ready, wrapping naturally
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_frame_cnt <= 16'd0;
        end else if ((state == ST_WAIT_RDY) && i_rdy) begin
            o_frame_cnt <= o_frame_cnt + 16'd1;
        end
    end

`ifdef SHIFT_CTRL_TIMEOUT_EN
    localparam int TW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 1);

    logic [TW-1:0] to_count;

    assign timeout = (state == ST_WAIT_RDY) && !i_rdy && (to_count == TO_LAST);

    // Count unanswered WAIT_RDY cycles; flag a sticky error when the budget runs out
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            to_count <= '0;
            o_err    <= 1'b0;
        end else if ((state == ST_WAIT_RDY) && !i_rdy) begin
            if (timeout) begin
                to_count <= '0;
                o_err    <= 1'b1;
            end else begin
                to_count <= to_count + TW'(1);
            end
        end else begin
            to_count <= '0;
        end
    end
`else
    logic [31:0] unused_to_cyc;

    assign unused_to_cyc = 32'(TO_CYC);
    assign timeout       = 1'b0;
    assign o_err         = 1'b0;
`endif

endmodule
`default_nettype wire
